inst_mem: RTL and testbench
===========================

# inst_mem

Instruction memory responder for the fetch stage: the target end of the fetch interface driven by the PC register. It accepts a fetch address qualified by a chip-enable and returns the addressed 32-bit instruction with a registered, optionally wait-stated response. It also provides a flag for misaligned or out-of-range fetches and a word-write load port used by the testbench and boot loader to fill the array.

## Interface
- DEPTH_LOG2, 10: log2 of memory depth in 32-bit words (default 1024 words = 4 KiB).
- WAIT_CYCLES, 0: extra response latency in cycles (0..15).
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ce  in  1  fetch request enable (high = fetch at addr).
- addr  in  32  byte address of the instruction.
- inst  out  32  fetched instruction, registered.
- inst_valid  out  1  inst holds a response for the last accepted request.
- addr_err  out  1  the current response is for a misaligned or out-of-range address.
- stall  out  1  a request is accepted and its response is pending (wait states).
- load_en  in  1  write strobe for the load port.
- load_addr  in  DEPTH_LOG2  word index to write.
- load_data  in  32  word to write.

## Operation
- Storage: DEPTH = 2^DEPTH_LOG2 words; contents not affected by reset. Word index = addr[DEPTH_LOG2+1:2].
- Load port: at a rising edge with load_en=1, mem[load_addr] <= load_data. Independent of the fetch FSM; legal in any state.
- FSM states: IDLE, WAIT. Counter cnt, 4 bits.
- IDLE, ce=0: inst<=0, inst_valid<=0, addr_err<=0, stall<=0.
- IDLE, ce=1, WAIT_CYCLES=0: respond at this edge (see Response). Remain in IDLE.
- IDLE, ce=1, WAIT_CYCLES=N>0: latch addr, cnt<=N, stall<=1, inst_valid<=0, addr_err<=0, go to WAIT.
- WAIT, ce=1: addr input ignored; the latched address is used. If cnt==1: respond from latched address, stall<=0, go to IDLE. Else cnt<=cnt-1.
- WAIT, ce=0: abort. Go to IDLE, stall<=0, inst_valid<=0, inst<=0, addr_err<=0. No response is issued.
- Response: if address[1:0]!=0, or address[31:DEPTH_LOG2+2]!=0, then inst<=32'h0 (NOP), addr_err<=1, inst_valid<=1. Otherwise inst<=mem[index], addr_err<=0, inst_valid<=1.
- Read/load collision at the same edge on the same word: the response returns the old contents (read-before-write). The new word is visible to the next fetch.

## Timing
- Reset (async assert): inst=0, inst_valid=0, addr_err=0, stall=0, state=IDLE, cnt=0, applied immediately without waiting for clk. Reset mid-WAIT discards the pending request.
- Latency: a request sampled at edge E0 produces its response visible after edge E0+WAIT_CYCLES.
- Throughput: WAIT_CYCLES=0 gives one response per cycle, back-to-back. N>0 gives one request per N+1 cycles. A new request is sampled only in IDLE, so the first IDLE edge after a response can accept the next request.
- stall is high from the edge after acceptance through the response edge (exclusive), for exactly N cycles.
- inst_valid, addr_err, and inst hold their value from one response until the next edge that changes them. With WAIT_CYCLES=0 and ce held high, inst_valid stays 1.

## Test plan
- Reset: assert rst asynchronously mid-cycle. All outputs go to 0 immediately. Release rst, hold ce=0: outputs stay 0.
- Load mem[0..2]=0x11111111/0x22222222/0x33333333, WAIT_CYCLES=0, ce=1, addr 0,4,8 on consecutive cycles. inst shows the three words one cycle later each, inst_valid=1 throughout, addr_err=0.
- Errors with DEPTH_LOG2=10: addr=0x00000002 gives inst=0, addr_err=1, inst_valid=1. addr=0x00001000 gives the same. The next fetch at 0x4 clears addr_err.
- WAIT_CYCLES=2, fetch addr 4 at E0 (addr changed to 0x8 during wait). stall=1 after E0 and E1. After E2: inst=0x22222222, inst_valid=1, stall=0.
- Abort and reset: WAIT_CYCLES=3, request accepted, ce dropped after one wait cycle. FSM returns to IDLE, no inst_valid pulse. Repeat with async rst mid-WAIT: stall=0 immediately, and a new request after reset gets normal latency.
- Collision: WAIT_CYCLES=0, mem[1]=0xAAAAAAAA. Same edge: fetch addr 4 with load_en=1, load_addr=1, load_data=0xBBBBBBBB. inst=0xAAAAAAAA. Next fetch of addr 4 returns 0xBBBBBBBB.

Source files
------------

// File: rtl/inst_mem_if.sv
// inst_mem_if: fetch request/response and word-load signals between the PC side and instruction memory.
interface inst_mem_if #(
    parameter int DEPTH_LOG2 = 10
);
    logic                  ce;
    logic [31:0]           addr;
    logic [31:0]           inst;
    logic                  inst_valid;
    logic                  addr_err;
    logic                  stall;
    logic                  load_en;
    logic [DEPTH_LOG2-1:0] load_addr;
    logic [31:0]           load_data;
    modport master (
        output ce, addr, load_en, load_addr, load_data,
        input  inst, inst_valid, addr_err, stall
    );
    modport slave (
        input  ce, addr, load_en, load_addr, load_data,
        output inst, inst_valid, addr_err, stall
    );
endinterface

// File: rtl/inst_mem.sv
// inst_mem: instruction memory fetch responder with optional wait states and a word load port.
module inst_mem #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input logic       clk,
    input logic       rst,
    inst_mem_if.slave bus
);
    typedef enum logic {IDLE, WAIT} state_t;
    logic [31:0] r_mem [2**DEPTH_LOG2];
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_inst;
    logic        r_valid;
    logic        r_err;
    logic        r_stall;
    logic [31:0] w_addr;
    logic [31:0] w_resp;
    logic        w_err;
    // While waiting, the address latched at acceptance is used, not the live bus
    assign w_addr = (r_state == WAIT) ? r_addr : bus.addr;
    assign w_err  = (w_addr[1:0] != 2'b0) || (w_addr[31:DEPTH_LOG2+2] != '0);
    assign w_resp = w_err ? 32'h0 : r_mem[w_addr[DEPTH_LOG2+1:2]];
    assign bus.inst       = r_inst;
    assign bus.inst_valid = r_valid;
    assign bus.addr_err   = r_err;
    assign bus.stall      = r_stall;
    always_ff @(posedge clk) begin
        if (bus.load_en) r_mem[bus.load_addr] <= bus.load_data;
    end
    // ce low clears outputs in IDLE and aborts a pending request in WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'h0;
            r_inst  <= 32'h0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_stall <= 1'b0;
        end else if (!bus.ce) begin
            r_state <= IDLE;
            r_inst  <= 32'h0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_stall <= 1'b0;
        end else if (r_state == IDLE && WAIT_CYCLES > 0) begin
            r_state <= WAIT;
            r_addr  <= bus.addr;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_stall <= 1'b1;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else if (r_state == IDLE || r_cnt == 4'd1) begin
            r_state <= IDLE;
            r_inst  <= w_resp;
            r_valid <= 1'b1;
            r_err   <= w_err;
            r_stall <= 1'b0;
        end else begin
            r_cnt <= r_cnt - 4'd1;
        end
    end
endmodule

// File: tb/tb_inst_mem.sv
// tb_inst_mem: directed bench for inst_mem at 0, 2 and 3 wait states with a response scoreboard.
module tb_inst_mem;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inst_mem_if #(.DEPTH_LOG2(10)) b0();
    inst_mem_if #(.DEPTH_LOG2(10)) b2();
    inst_mem_if #(.DEPTH_LOG2(10)) b3();
    inst_mem #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    inst_mem #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
    inst_mem #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } exp_t;
    exp_t        q[$];
    logic [31:0] m [1024];
    logic [31:0] seq [6] = '{32'h0, 32'h4, 32'h8, 32'h2, 32'h1000, 32'h4};
    int          checks = 0;
    int          failures = 0;
    int          lat;
    int          pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag, input logic [31:0] inst, input logic v,
                            input logic err, input logic stall);
        chk({tag, ".inst"}, inst, 32'h0);
        chk({tag, ".valid"}, 32'(v), 32'h0);
        chk({tag, ".err"}, 32'(err), 32'h0);
        chk({tag, ".stall"}, 32'(stall), 32'h0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [31:0] a);
        exp_t e;
        e.err  = (a[1:0] != 2'b0) || (a[31:12] != 20'h0);
        e.inst = e.err ? 32'h0 : m[a[11:2]];
        return e;
    endfunction

    task automatic push(input logic [31:0] a);
        q.push_back(model(a));
    endtask

    task automatic pop_chk(input string tag, input logic v, input logic [31:0] inst, input logic err);
        exp_t e;
        chk({tag, ".valid"}, 32'(v), 32'h1);
        if (q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s.scoreboard observed=response expected=none_pending", tag);
        end else begin
            e = q.pop_front();
            chk({tag, ".inst"}, inst, e.inst);
            chk({tag, ".err"}, 32'(err), 32'(e.err));
        end
    endtask

    task automatic load(input int unsigned i, input logic [31:0] d);
        b0.load_en = 1'b1; b0.load_addr = 10'(i); b0.load_data = d;
        b2.load_en = 1'b1; b2.load_addr = 10'(i); b2.load_data = d;
        b3.load_en = 1'b1; b3.load_addr = 10'(i); b3.load_data = d;
        m[i] = d;
        tick();
        b0.load_en = 1'b0;
        b2.load_en = 1'b0;
        b3.load_en = 1'b0;
    endtask

    initial begin
        b0.ce = 0; b0.addr = 0; b0.load_en = 0; b0.load_addr = 0; b0.load_data = 0;
        b2.ce = 0; b2.addr = 0; b2.load_en = 0; b2.load_addr = 0; b2.load_data = 0;
        b3.ce = 0; b3.addr = 0; b3.load_en = 0; b3.load_addr = 0; b3.load_data = 0;
        #3 rst = 1'b1;
        #1;
        chk_zero("rst_async_w0", b0.inst, b0.inst_valid, b0.addr_err, b0.stall);
        chk_zero("rst_async_w2", b2.inst, b2.inst_valid, b2.addr_err, b2.stall);
        chk_zero("rst_async_w3", b3.inst, b3.inst_valid, b3.addr_err, b3.stall);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk_zero("post_rst_w0", b0.inst, b0.inst_valid, b0.addr_err, b0.stall);
        chk_zero("post_rst_w2", b2.inst, b2.inst_valid, b2.addr_err, b2.stall);

        load(0, 32'h11111111);
        load(1, 32'h22222222);
        load(2, 32'h33333333);

        // back-to-back fetches, including misaligned and out-of-range addresses
        for (int i = 0; i < 6; i++) begin
            b0.ce = 1'b1;
            b0.addr = seq[i];
            push(seq[i]);
            tick();
            pop_chk($sformatf("w0.fetch%0d", i), b0.inst_valid, b0.inst, b0.addr_err);
            chk($sformatf("w0.stall%0d", i), 32'(b0.stall), 32'h0);
        end
        b0.ce = 1'b0;
        tick();
        chk_zero("w0.ce_low", b0.inst, b0.inst_valid, b0.addr_err, b0.stall);

        // two wait states, address changes during the wait
        b2.ce = 1'b1;
        b2.addr = 32'h4;
        push(32'h4);
        tick();
        chk("w2.stall_e0", 32'(b2.stall), 32'h1);
        chk("w2.valid_e0", 32'(b2.inst_valid), 32'h0);
        b2.addr = 32'h8;
        tick();
        chk("w2.stall_e1", 32'(b2.stall), 32'h1);
        chk("w2.valid_e1", 32'(b2.inst_valid), 32'h0);
        tick();
        chk("w2.stall_e2", 32'(b2.stall), 32'h0);
        pop_chk("w2.resp", b2.inst_valid, b2.inst, b2.addr_err);
        b2.ce = 1'b0;
        tick();

        // abort after one wait cycle
        b3.ce = 1'b1;
        b3.addr = 32'h0;
        tick();
        chk("w3.stall_e0", 32'(b3.stall), 32'h1);
        tick();
        chk("w3.stall_e1", 32'(b3.stall), 32'h1);
        b3.ce = 1'b0;
        tick();
        chk_zero("w3.abort", b3.inst, b3.inst_valid, b3.addr_err, b3.stall);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (b3.inst_valid) pulses++;
        end
        chk("w3.no_resp", 32'(pulses), 32'h0);

        // async reset in the middle of a wait
        b3.ce = 1'b1;
        b3.addr = 32'h8;
        tick();
        tick();
        chk("w3.stall_pre_rst", 32'(b3.stall), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk_zero("w3.rst_mid", b3.inst, b3.inst_valid, b3.addr_err, b3.stall);
        b3.ce = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        b3.ce = 1'b1;
        b3.addr = 32'h8;
        push(32'h8);
        tick();
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (b3.inst_valid) begin
                lat = c;
                break;
            end
        end
        chk("w3.latency", 32'(lat), 32'h3);
        pop_chk("w3.resp", b3.inst_valid, b3.inst, b3.addr_err);
        b3.ce = 1'b0;
        tick();

        // read-before-write on a same-edge collision
        load(1, 32'hAAAAAAAA);
        b0.ce = 1'b1;
        b0.addr = 32'h4;
        push(32'h4);
        b0.load_en = 1'b1;
        b0.load_addr = 10'd1;
        b0.load_data = 32'hBBBBBBBB;
        m[1] = 32'hBBBBBBBB;
        tick();
        b0.load_en = 1'b0;
        pop_chk("coll.old", b0.inst_valid, b0.inst, b0.addr_err);
        push(32'h4);
        tick();
        pop_chk("coll.new", b0.inst_valid, b0.inst, b0.addr_err);
        b0.ce = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
